// File: rtl/test_pattern_gen.sv
// test_pattern_gen
// Stimulus source for the capture path (delay line -> circular buffer). Emits an
// incrementing sample word, a single trigger pulse and a check-window flag, one
// capture sequence per start. All outputs are registered.
module test_pattern_gen #(
  parameter int DATA_WIDTH      = 16,
  parameter int MEMORY_SIZE     = 16,
  parameter int ALIGNMENT_DELAY = 2,
  parameter int USER_HOLDOFF    = 4,
  parameter int TRIGGER_AT      = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  pause,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  data_valid,
  output logic                  trigger,
  output logic                  expect_valid,
  output logic                  done
);

  localparam int     HOLD_W = USER_HOLDOFF + MEMORY_SIZE + ALIGNMENT_DELAY + 1;
  localparam longint LAST   = longint'(TRIGGER_AT) + longint'(HOLD_W) + longint'(MEMORY_SIZE);

  localparam logic [DATA_WIDTH-1:0] C_TRIG   = DATA_WIDTH'(TRIGGER_AT);
  localparam logic [DATA_WIDTH-1:0] C_LAST   = DATA_WIDTH'(LAST);
  localparam logic [DATA_WIDTH-1:0] C_ONE    = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH:0]   C_WIN_LO = (DATA_WIDTH+1)'(HOLD_W);
  localparam logic [DATA_WIDTH:0]   C_WIN_HI = (DATA_WIDTH+1)'(HOLD_W + MEMORY_SIZE);

  // The whole sequence must fit below the wrap point so the window is contiguous
  if (LAST >= (longint'(1) << DATA_WIDTH)) begin : g_lastTooLarge
    $error("test_pattern_gen: final sample value exceeds the DATA_WIDTH range");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRETRIG,
    S_POSTTRIG,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_stateNext;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_trigger;
  logic                  r_expect;
  logic                  r_done;
  logic                  r_pending;

  logic [DATA_WIDTH-1:0] w_dataNext;
  logic                  w_validNext;
  logic                  w_triggerNext;
  logic                  w_expectNext;
  logic                  w_doneNext;
  logic                  w_pendingNext;
  logic [DATA_WIDTH:0]   w_diff;

  logic                  w_running;
  logic                  w_launch;
  logic                  w_launchTrig;
  logic                  w_finish;
  logic                  w_advance;
  logic                  w_hitTrig;
  logic [DATA_WIDTH-1:0] w_issueData;

  // Decode the events for this edge: launch, finish, advance and trigger hit.
  // r_pending marks a sample word that has not yet gone out valid (the first 0
  // when start arrived with pause high), so it is issued rather than skipped.
  always_comb begin
    w_running    = (r_state == S_PRETRIG) || (r_state == S_POSTTRIG);
    w_launch     = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
    w_launchTrig = w_launch && !pause && (C_TRIG == '0);
    w_finish     = (r_state == S_POSTTRIG) && r_valid && (r_data == C_LAST);
    w_advance    = w_running && !pause && !w_finish;
    w_issueData  = r_pending ? r_data : (r_data + C_ONE);
    w_hitTrig    = w_advance && (r_state == S_PRETRIG) && (w_issueData == C_TRIG);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic; the trigger cycle itself moves us into POSTTRIG
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_stateNext = w_launchTrig ? S_POSTTRIG : S_PRETRIG;
        end
      end
      S_PRETRIG: begin
        if (w_hitTrig) begin
          w_stateNext = S_POSTTRIG;
        end
      end
      S_POSTTRIG: begin
        if (w_finish) begin
          w_stateNext = S_DONE;
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, including the check-window compare
  always_comb begin
    w_dataNext    = r_data;
    w_validNext   = 1'b0;
    w_triggerNext = 1'b0;
    w_doneNext    = r_done;
    w_pendingNext = r_pending;
    if (w_launch) begin
      w_dataNext    = '0;
      w_validNext   = !pause;
      w_triggerNext = w_launchTrig;
      w_doneNext    = 1'b0;
      w_pendingNext = pause;
    end else if (w_finish) begin
      w_doneNext    = 1'b1;
      w_pendingNext = 1'b0;
    end else if (w_advance) begin
      w_dataNext    = w_issueData;
      w_validNext   = 1'b1;
      w_triggerNext = w_hitTrig;
      w_pendingNext = 1'b0;
    end
    w_diff       = {1'b0, w_dataNext} - {1'b0, C_TRIG};
    w_expectNext = w_validNext && (w_diff > C_WIN_LO) && (w_diff <= C_WIN_HI);
  end

  // Output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_trigger <= 1'b0;
      r_expect  <= 1'b0;
      r_done    <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_data    <= w_dataNext;
      r_valid   <= w_validNext;
      r_trigger <= w_triggerNext;
      r_expect  <= w_expectNext;
      r_done    <= w_doneNext;
      r_pending <= w_pendingNext;
    end
  end

  assign data_in      = r_data;
  assign data_valid   = r_valid;
  assign trigger      = r_trigger;
  assign expect_valid = r_expect;
  assign done         = r_done;

endmodule
